// File: rtl/tri_rasterizer.sv
// tri_rasterizer
//   Renders a frame of flat-coloured triangles into a framebuffer. A frame is
//   requested with frame_start. The framebuffer is optionally cleared first.
//   Then tri_count triangle records are fetched from VRAM one at a time. Each
//   triangle's screen-clamped bounding box is scanned in raster order, and
//   every covered pixel is written in the triangle's colour.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   frame_start    one-cycle frame request, honoured only while idle
//   tri_count      number of triangle records to draw (sampled with frame_start)
//   clear_en       clear the framebuffer first (sampled with frame_start)
//   busy           frame in progress
//   frame_done     one-cycle pulse at the end of a frame
//   vram_rd_en     VRAM read strobe
//   vram_rd_addr   VRAM record index
//   vram_rd_data   VRAM record data, valid one cycle after vram_rd_en
//                  layout (MSB first): x0,y0,x1,y1,x2,y2,color
//   fb_wr_en       framebuffer write valid
//   fb_wr_addr     pixel address, x + DISPLAY_WIDTH*y
//   fb_wr_data     pixel colour
//   fb_wr_ready    framebuffer write ready
//   fsm_state      current controller state, for observation
//
// Handshake: a framebuffer write completes on a cycle where fb_wr_en and
// fb_wr_ready are both high. Once fb_wr_en is raised, fb_wr_en, fb_wr_addr
// and fb_wr_data are held stable until that cycle. fb_wr_ready may be low
// for any number of cycles.
module tri_rasterizer #(
    parameter int DISPLAY_WIDTH         = 100,
    parameter int DISPLAY_HEIGHT        = 100,
    parameter int COORD_BITS            = 8,
    parameter int COLOR_BITS            = 16,
    parameter int VRAM_ADDR_BITS        = 6,
    parameter int VRAM_DATA_BITS        = 6*COORD_BITS+COLOR_BITS,
    parameter int FRAMEBUFFER_ADDR_BITS = $clog2(DISPLAY_WIDTH*DISPLAY_HEIGHT),
    parameter logic [COLOR_BITS-1:0] CLEAR_COLOR = '0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             frame_start,
    input  logic [VRAM_ADDR_BITS:0]          tri_count,
    input  logic                             clear_en,
    output logic                             busy,
    output logic                             frame_done,
    output logic                             vram_rd_en,
    output logic [VRAM_ADDR_BITS-1:0]        vram_rd_addr,
    input  logic [VRAM_DATA_BITS-1:0]        vram_rd_data,
    output logic                             fb_wr_en,
    output logic [FRAMEBUFFER_ADDR_BITS-1:0] fb_wr_addr,
    output logic [COLOR_BITS-1:0]            fb_wr_data,
    input  logic                             fb_wr_ready,
    output logic [2:0]                       fsm_state
);

    localparam int C  = COORD_BITS;
    localparam int EW = 2*COORD_BITS+2;   // edge-function / area width
    localparam int FB = FRAMEBUFFER_ADDR_BITS;
    localparam logic [FB-1:0] LAST_PIX = FB'(DISPLAY_WIDTH*DISPLAY_HEIGHT-1);
    localparam logic [C-1:0]  X_LIM    = C'(DISPLAY_WIDTH-1);
    localparam logic [C-1:0]  Y_LIM    = C'(DISPLAY_HEIGHT-1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FETCH = 3'd2,
        S_LATCH = 3'd3,
        S_SETUP = 3'd4,
        S_SCAN  = 3'd5,
        S_NEXT  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t state, state_nxt;

    logic [VRAM_ADDR_BITS:0] cnt_q;
    logic [VRAM_ADDR_BITS:0] idx_q;
    logic [FB-1:0]           clr_addr_q;
    logic [C-1:0]            x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
    logic [COLOR_BITS-1:0]   color_q;
    logic [C-1:0]            min_x_q, max_x_q, min_y_q, max_y_q;
    logic [C-1:0]            sx_q, sy_q;

    // Edge function of point p against the directed edge a->b. Operands are
    // zero-extended to EW bits so that differences and products are exact.
    function automatic logic signed [EW-1:0] edge_fn(
        input logic [C-1:0] ax, input logic [C-1:0] ay,
        input logic [C-1:0] bx, input logic [C-1:0] by,
        input logic [C-1:0] px, input logic [C-1:0] py);
        logic signed [EW-1:0] sax, say, sbx, sby, spx, spy;
        sax = $signed({{(EW-C){1'b0}}, ax});
        say = $signed({{(EW-C){1'b0}}, ay});
        sbx = $signed({{(EW-C){1'b0}}, bx});
        sby = $signed({{(EW-C){1'b0}}, by});
        spx = $signed({{(EW-C){1'b0}}, px});
        spy = $signed({{(EW-C){1'b0}}, py});
        return (sbx - sax) * (spy - say) - (sby - say) * (spx - sax);
    endfunction

    function automatic logic [C-1:0] min3(input logic [C-1:0] a,
                                          input logic [C-1:0] b,
                                          input logic [C-1:0] c);
        logic [C-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [C-1:0] max3(input logic [C-1:0] a,
                                          input logic [C-1:0] b,
                                          input logic [C-1:0] c);
        logic [C-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // Triangle setup. Coordinates are unsigned, so only the upper bounds
    // need clamping. A box that starts beyond the screen edge comes out
    // empty (min > clamped max).
    logic [C-1:0]         bx_min, bx_max, by_min, by_max, bx_max_c, by_max_c;
    logic signed [EW-1:0] area;
    logic                 skip_tri;

    always_comb begin
        bx_min   = min3(x0_q, x1_q, x2_q);
        bx_max   = max3(x0_q, x1_q, x2_q);
        by_min   = min3(y0_q, y1_q, y2_q);
        by_max   = max3(y0_q, y1_q, y2_q);
        bx_max_c = (bx_max > X_LIM) ? X_LIM : bx_max;
        by_max_c = (by_max > Y_LIM) ? Y_LIM : by_max;
        area     = edge_fn(x0_q, y0_q, x1_q, y1_q, x2_q, y2_q);
        skip_tri = (area == '0) || (bx_min > bx_max_c) || (by_min > by_max_c);
    end

    // Coverage at the current scan pixel. Accepting all-nonnegative or
    // all-nonpositive handles both windings and keeps edge and vertex pixels.
    logic signed [EW-1:0] e0, e1, e2;
    logic                 all_pos, all_neg, covered;
    logic                 last_x, last_pix, advance;
    logic [FB-1:0]        pix_addr;

    always_comb begin
        e0       = edge_fn(x0_q, y0_q, x1_q, y1_q, sx_q, sy_q);
        e1       = edge_fn(x1_q, y1_q, x2_q, y2_q, sx_q, sy_q);
        e2       = edge_fn(x2_q, y2_q, x0_q, y0_q, sx_q, sy_q);
        all_pos  = !e0[EW-1] && !e1[EW-1] && !e2[EW-1];
        all_neg  = (e0[EW-1] || e0 == '0) && (e1[EW-1] || e1 == '0)
                && (e2[EW-1] || e2 == '0);
        covered  = all_pos || all_neg;
        last_x   = (sx_q == max_x_q);
        last_pix = last_x && (sy_q == max_y_q);
        // Uncovered pixels advance immediately. Covered ones wait for the write.
        advance  = !covered || fb_wr_ready;
        pix_addr = FB'(sy_q) * FB'(DISPLAY_WIDTH) + FB'(sx_q);
    end

    // Next state and outputs
    always_comb begin
        state_nxt    = state;
        busy         = 1'b0;
        frame_done   = 1'b0;
        vram_rd_en   = 1'b0;
        vram_rd_addr = idx_q[VRAM_ADDR_BITS-1:0];
        fb_wr_en     = 1'b0;
        fb_wr_addr   = '0;
        fb_wr_data   = '0;
        case (state)
            S_IDLE: begin
                if (frame_start) begin
                    if (clear_en)            state_nxt = S_CLEAR;
                    else if (tri_count != '0) state_nxt = S_FETCH;
                    else                     state_nxt = S_DONE;
                end
            end
            S_CLEAR: begin
                busy       = 1'b1;
                fb_wr_en   = 1'b1;
                fb_wr_addr = clr_addr_q;
                fb_wr_data = CLEAR_COLOR;
                if (fb_wr_ready && clr_addr_q == LAST_PIX)
                    state_nxt = (cnt_q != '0) ? S_FETCH : S_DONE;
            end
            S_FETCH: begin
                busy       = 1'b1;
                vram_rd_en = 1'b1;
                state_nxt  = S_LATCH;
            end
            S_LATCH: begin
                busy      = 1'b1;
                state_nxt = S_SETUP;
            end
            S_SETUP: begin
                busy      = 1'b1;
                state_nxt = skip_tri ? S_NEXT : S_SCAN;
            end
            S_SCAN: begin
                busy       = 1'b1;
                fb_wr_en   = covered;
                fb_wr_addr = pix_addr;
                fb_wr_data = covered ? color_q : '0;
                if (advance && last_pix) state_nxt = S_NEXT;
            end
            S_NEXT: begin
                busy      = 1'b1;
                state_nxt = ((idx_q + 1'b1) < cnt_q) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign fsm_state = state;

    // State register and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            clr_addr_q <= '0;
            x0_q       <= '0;
            y0_q       <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            color_q    <= '0;
            min_x_q    <= '0;
            max_x_q    <= '0;
            min_y_q    <= '0;
            max_y_q    <= '0;
            sx_q       <= '0;
            sy_q       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        cnt_q      <= tri_count;
                        idx_q      <= '0;
                        clr_addr_q <= '0;
                    end
                end
                S_CLEAR: begin
                    if (fb_wr_ready) clr_addr_q <= clr_addr_q + 1'b1;
                end
                S_LATCH: begin
                    x0_q    <= vram_rd_data[VRAM_DATA_BITS-1        -: C];
                    y0_q    <= vram_rd_data[VRAM_DATA_BITS-1-C      -: C];
                    x1_q    <= vram_rd_data[VRAM_DATA_BITS-1-2*C    -: C];
                    y1_q    <= vram_rd_data[VRAM_DATA_BITS-1-3*C    -: C];
                    x2_q    <= vram_rd_data[VRAM_DATA_BITS-1-4*C    -: C];
                    y2_q    <= vram_rd_data[VRAM_DATA_BITS-1-5*C    -: C];
                    color_q <= vram_rd_data[COLOR_BITS-1:0];
                end
                S_SETUP: begin
                    min_x_q <= bx_min;
                    max_x_q <= bx_max_c;
                    min_y_q <= by_min;
                    max_y_q <= by_max_c;
                    sx_q    <= bx_min;
                    sy_q    <= by_min;
                end
                S_SCAN: begin
                    if (advance) begin
                        if (last_x) begin
                            sx_q <= min_x_q;
                            sy_q <= sy_q + 1'b1;
                        end else begin
                            sx_q <= sx_q + 1'b1;
                        end
                    end
                end
                S_NEXT: begin
                    idx_q <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_rasterizer.sv
module tb_tri_rasterizer;

  localparam int W  = 100;
  localparam int H  = 100;
  localparam int C  = 8;
  localparam int CB = 16;
  localparam int AB = 6;
  localparam int DB = 6*C+CB;
  localparam int FB = 14;
  localparam int SW = FB+CB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AB:0]   tri_count = '0;
  logic          clear_en = 1'b0;
  logic          busy, frame_done, vram_rd_en, fb_wr_en;
  logic [AB-1:0] vram_rd_addr;
  logic [DB-1:0] vram_rd_data = '0;
  logic [FB-1:0] fb_wr_addr;
  logic [CB-1:0] fb_wr_data;
  logic          fb_wr_ready = 1'b1;
  logic [2:0]    fsm_state;

  tri_rasterizer dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .tri_count(tri_count),
    .clear_en(clear_en), .busy(busy), .frame_done(frame_done),
    .vram_rd_en(vram_rd_en), .vram_rd_addr(vram_rd_addr),
    .vram_rd_data(vram_rd_data), .fb_wr_en(fb_wr_en),
    .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_wr_ready(fb_wr_ready), .fsm_state(fsm_state)
  );

  // VRAM model: registered read, data one cycle after the strobe
  logic [DB-1:0] vram [0:63];
  always @(posedge clk) if (vram_rd_en) vram_rd_data <= vram[vram_rd_addr];

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int wr_cnt = 0;
  bit stall_mode = 1'b0;
  logic [SW-1:0] exp_q[$];
  logic [AB-1:0] rd_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic miss(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event, expected none (or timed out) at %0t", name, $time);
  endtask

  // ---------------- monitor ----------------
  logic          stall_prev = 1'b0;
  logic [FB-1:0] stall_addr = '0;
  logic [CB-1:0] stall_data = '0;

  always @(negedge clk) begin
    if (!rst) begin
      if (stall_prev) begin
        check("stall_hold_en", fb_wr_en, 1);
        check("stall_hold_addr", fb_wr_addr, stall_addr);
        check("stall_hold_data", fb_wr_data, stall_data);
      end
      stall_prev <= fb_wr_en && !fb_wr_ready;
      stall_addr <= fb_wr_addr;
      stall_data <= fb_wr_data;
      if (fb_wr_en && fb_wr_ready) begin
        check("busy_during_write", busy, 1);
        if (exp_q.size() == 0) miss("unexpected_write");
        else check("write_addr_data", {fb_wr_addr, fb_wr_data}, exp_q.pop_front());
        wr_cnt++;
      end
      if (vram_rd_en) begin
        if (rd_q.size() == 0) miss("unexpected_vram_read");
        else check("vram_rd_addr", vram_rd_addr, rd_q.pop_front());
      end
      if (frame_done) begin
        done_cnt++;
        check("writes_left_at_done", exp_q.size(), 0);
        check("reads_left_at_done", rd_q.size(), 0);
        check("busy_at_done", busy, 0);
      end
    end
  end

  // Write-ready driver: always ready, or ready about one cycle in three
  initial begin
    forever begin
      @(posedge clk);
      #1;
      fb_wr_ready = stall_mode ? ($urandom_range(0, 2) == 2) : 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DB-1:0] mk_rec(input int x0, input int y0, input int x1,
                                           input int y1, input int x2, input int y2,
                                           input logic [CB-1:0] col);
    return {C'(x0), C'(y0), C'(x1), C'(y1), C'(x2), C'(y2), col};
  endfunction

  // Right-angle triangle with legs of length l along +x and +y from (x0,y0):
  // covered pixels satisfy (x-x0)+(y-y0) <= l, clipped to the screen.
  task automatic push_rt(input int x0, input int y0, input int l, input logic [CB-1:0] col);
    logic [FB-1:0] a;
    for (int y = y0; y <= y0 + l && y < H; y++)
      for (int x = x0; x <= x0 + l - (y - y0) && x < W; x++) begin
        a = FB'(x + W*y);
        exp_q.push_back({a, col});
      end
  endtask

  task automatic start_frame(input int cnt, input bit clr);
    frame_start = 1'b1;
    tri_count = (AB+1)'(cnt);
    clear_en = clr;
    tick();
    frame_start = 1'b0;
    clear_en = 1'b0;
    check("busy_after_start", busy, 1);
  endtask

  task automatic run_frame(input int cnt, input bit clr, input int budget);
    bit finished;
    start_frame(cnt, clr);
    finished = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (frame_done) begin
        finished = 1'b1;
        break;
      end
      tick();
    end
    if (!finished) miss("frame_timeout");
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin : main
    int d0;
    int w0;
    bit hit;
    logic [FB-1:0] a;

    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_vram_rd_en", vram_rd_en, 0);
    check("rst_vram_rd_addr", vram_rd_addr, 0);
    check("rst_fb_wr_en", fb_wr_en, 0);
    check("rst_fb_wr_addr", fb_wr_addr, 0);
    check("rst_fb_wr_data", fb_wr_data, 0);
    check("rst_state_idle", fsm_state, 0);
    rst = 1'b0;
    tick();

    // Clear only: every address in order with colour 0
    for (int i = 0; i < W*H; i++) begin
      a = FB'(i);
      exp_q.push_back({a, 16'h0000});
    end
    run_frame(0, 1'b1, W*H + 100);
    check("done_count_clear", done_cnt, 1);

    // One triangle, no clear
    vram[0] = mk_rec(10, 10, 20, 10, 10, 20, 16'hF800);
    rd_q.push_back(0);
    push_rt(10, 10, 10, 16'hF800);
    check("expected_count_66", exp_q.size(), 66);
    run_frame(1, 1'b0, 500);
    check("done_count_tri", done_cnt, 2);

    // Opposite winding: identical output
    vram[0] = mk_rec(10, 10, 10, 20, 20, 10, 16'hF800);
    rd_q.push_back(0);
    push_rt(10, 10, 10, 16'hF800);
    run_frame(1, 1'b0, 500);
    check("done_count_winding", done_cnt, 3);

    // Same triangle with a stalling write port
    stall_mode = 1'b1;
    rd_q.push_back(0);
    push_rt(10, 10, 10, 16'hF800);
    run_frame(1, 1'b0, 3000);
    stall_mode = 1'b0;
    tick();
    check("done_count_stall", done_cnt, 4);

    // Degenerate triangle skipped, then a small one
    vram[0] = mk_rec(0, 0, 5, 5, 9, 9, 16'h1234);
    vram[1] = mk_rec(0, 0, 3, 0, 0, 3, 16'h07E0);
    rd_q.push_back(0);
    rd_q.push_back(1);
    push_rt(0, 0, 3, 16'h07E0);
    check("expected_count_10", exp_q.size(), 10);
    run_frame(2, 1'b0, 500);
    check("done_count_degen", done_cnt, 5);

    // Triangle reaching past the screen edge: clipped to 90..99 on both axes
    vram[0] = mk_rec(90, 90, 150, 90, 90, 150, 16'h001F);
    rd_q.push_back(0);
    push_rt(90, 90, 60, 16'h001F);
    check("expected_count_clip", exp_q.size(), 100);
    run_frame(1, 1'b0, 500);
    check("done_count_clip", done_cnt, 6);

    // Reset in the middle of the scan
    rd_q.push_back(0);
    push_rt(90, 90, 60, 16'h001F);
    w0 = wr_cnt;
    start_frame(1, 1'b0);
    hit = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (wr_cnt >= w0 + 30) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    if (!hit) miss("midscan_wait_timeout");
    rst = 1'b1;
    tick();
    check("midrst_fb_wr_en", fb_wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state_idle", fsm_state, 0);
    exp_q.delete();
    rd_q.delete();
    rst = 1'b0;
    d0 = done_cnt;
    repeat (5) tick();
    check("no_done_after_reset", done_cnt, d0);

    // Fresh frame after the reset renders the full clipped triangle
    rd_q.push_back(0);
    push_rt(90, 90, 60, 16'h001F);
    run_frame(1, 1'b0, 500);
    check("done_count_after_reset", done_cnt, d0 + 1);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded time limit, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
